// File: rtl/if_prefetch_queue_pkg.sv
// if_prefetch_queue_pkg: fetch FSM encoding and instruction constants shared by the prefetch queue
package if_prefetch_queue_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DROP} fetch_state_e;
  localparam int INST_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/if_fifo_sync.sv
// if_fifo_sync: synchronous FIFO with clear; cleared slots hold a NOP so stale entries are recognisable in debug
module if_fifo_sync
  import if_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = 2 * INST_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         wr_en,
  input  logic [W-1:0]                 wr_data,
  input  logic                         rd_en,
  output logic [W-1:0]                 rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk)
    if (!rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= W'(NOP);
    end else begin
      if (wr_en) mem[wr_ptr] <= wr_data;
      wr_ptr <= wr_ptr + AW'(wr_en);
      rd_ptr <= rd_ptr + AW'(rd_en);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
endmodule

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: IF fetch engine feeding a prefetch FIFO; define IF_PREFETCH_QUEUE_BYPASS_EN to forward responses straight to deq when the FIFO is empty
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic                       imem_ack,
  input  logic [INST_W-1:0]          imem_rdata,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [31:0]                deq_pc,
  output logic [INST_W-1:0]          deq_inst,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH + 1);
  fetch_state_e state, state_nx;
  logic [31:0] fetch_pc, drop_addr;
  logic [CW-1:0] cnt_nx;
  logic [2*INST_W-1:0] head;
  logic empty, fetched, byp, enq, deq;
  assign empty = count == '0;
  assign fetched = state == REQ && imem_ack && !redirect;
`ifdef IF_PREFETCH_QUEUE_BYPASS_EN
  assign byp = fetched && empty;
`else
  assign byp = 1'b0;
`endif
  assign deq_valid = !empty || byp;
  assign deq = deq_ready && !empty && !redirect;
  assign enq = fetched && !(byp && deq_ready);
  assign cnt_nx = count + CW'(enq) - CW'(deq);
  assign imem_req = state != IDLE;
  assign imem_addr = state == DROP ? drop_addr : fetch_pc;
  assign deq_pc = !empty ? head[2*INST_W-1:INST_W] : byp ? fetch_pc : '0;
  assign deq_inst = !empty ? head[INST_W-1:0] : byp ? imem_rdata : '0;
  always_comb begin
    state_nx = state;
    if (redirect) state_nx = state != IDLE && !imem_ack ? DROP : REQ;
    else if (state == IDLE) state_nx = count < CW'(DEPTH) ? REQ : IDLE;
    else if (state == REQ) state_nx = imem_ack && cnt_nx == CW'(DEPTH) ? IDLE : REQ;
    else state_nx = imem_ack ? REQ : DROP;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      drop_addr <= RESET_PC;
    end else begin
      state <= state_nx;
      if (state == REQ) drop_addr <= fetch_pc;
      fetch_pc <= redirect ? {redirect_pc[31:2], 2'b00} : fetched ? fetch_pc + PC_INC : fetch_pc;
    end
  if_fifo_sync #(.DEPTH(DEPTH), .W(2 * INST_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .clr(redirect),
    .wr_en(enq),
    .wr_data({fetch_pc, imem_rdata}),
    .rd_en(deq),
    .rd_data(head),
    .count(count)
  );
endmodule
